mod_sram_arbiter: RTL and testbench
===================================

Name: mod_sram_arbiter

Overview:
- Shares the single SRAM controller port between three requesters: instruction-cache fill (I), data-cache fill/write-through (D) and the VGA frame fetcher (V).
- Sits between the cache hierarchy / VGA block and the SRAM controller.
- Serialises transactions, latches address and data per transaction, and returns read data with a one-cycle ack.
- Fixed priority D > I > V, with an aging override so VGA cannot starve.

Parameters:
ADDR_W, 32, requester/SRAM address width
DATA_W, 32, data word width
VGA_MAX_WAIT, 8, cycles V may wait while requesting before it is promoted to top priority

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  reset, asynchronous, active-low
i_req  in  1  I fill request, held until i_ack
i_addr  in  ADDR_W  I read address
i_rdata  out  DATA_W  I read data, valid when i_ack
i_ack  out  1  one-cycle completion pulse to I
d_req  in  1  D request, held until d_ack
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  D address
d_wdata  in  DATA_W  D write data
d_rdata  out  DATA_W  D read data, valid when d_ack on a read
d_ack  out  1  one-cycle completion pulse to D
v_req  in  1  VGA read request, held until v_ack
v_addr  in  ADDR_W  VGA read address
v_rdata  out  DATA_W  VGA read data, valid when v_ack
v_ack  out  1  one-cycle completion pulse to V
m_req  out  1  transaction request to SRAM controller
m_we  out  1  write enable to SRAM controller
m_addr  out  ADDR_W  latched transaction address
m_wdata  out  DATA_W  latched write data
m_rdata  in  DATA_W  SRAM read data, valid with m_done
m_done  in  1  SRAM controller completion strobe
grant  out  2  current owner: 00 none, 01 I, 10 D, 11 V (for debug/perf counters)

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; grant = 00; VGA wait counter = 0.
  - m_req, m_we and all acks = 0; m_addr, m_wdata and all rdata = 0.
- Reset asserted mid-transaction: m_req drops immediately and the transaction is abandoned; no ack is issued after release.
- States: IDLE, BUSY, RESP.
- IDLE:
  - Sample requests on the clock edge. If any is present, latch the winner's address, data and we, set grant, and go to BUSY.
  - No request: stay in IDLE.
- Arbitration order:
  - If v_req and vwait >= VGA_MAX_WAIT: V wins.
  - Otherwise D, then I, then V.
- BUSY:
  - m_req = 1. m_we is the latched we; it is 0 for I and V owners.
  - m_addr and m_wdata are held stable.
  - On m_done: register m_rdata into the owner's rdata register (reads only; on a D write, d_rdata is unchanged) and go to RESP.
- RESP:
  - The owner's ack is 1 for exactly one cycle. m_req = 0.
  - Next state is IDLE; grant returns to 00.
- Latency:
  - Request sampled in IDLE at edge k → m_req high in cycle k+1.
  - m_done in cycle n → ack in cycle n+1.
  - Zero-wait SRAM gives 3 cycles request-to-ack.
  - Minimum of one IDLE cycle between transactions.
- Requester rules:
  - Requester deasserts req on the edge that ends its ack cycle.
  - A request withdrawn before grant has no effect.
  - A request dropped during BUSY still completes and still acks.
  - Address and data are sampled only at grant; changes afterwards are ignored.
- VGA wait counter:
  - Increments each cycle v_req = 1 and V is not the owner.
  - Saturates at VGA_MAX_WAIT.
  - Clears to 0 when V is granted, or when v_req = 0.
- Simultaneous events:
  - m_done in any state other than BUSY is ignored.
  - Requests arriving during BUSY or RESP wait for IDLE.
  - Rdata registers of non-owners hold their last value.

Test Plan:
- Reset: drive rst low with d_req = 1 → all outputs 0 and grant = 00. Release rst → d_req sampled; m_req = 1 the next cycle with m_addr = d_addr.
- Single I read: i_addr = 0x0000_1000; controller returns m_done with m_rdata = 0xDEADBEEF after 4 cycles → i_ack pulses 1 cycle later with i_rdata = 0xDEADBEEF; m_we = 0 throughout.
- D write beats I: d_req (we = 1, addr 0x2004, wdata 0x12345678) and i_req asserted in the same cycle → D granted first with m_we = 1 and m_wdata = 0x12345678; d_rdata unchanged; I granted after the following IDLE cycle.
- VGA aging: v_req held while D and I alternately keep requesting → once vwait reaches 8, V is granted at the next IDLE despite pending D/I; v_ack returns v_rdata; counter clears to 0.
- Mid-operation reset: pulse rst low while BUSY → m_req falls immediately with no ack. After release, re-request of the same address completes normally.
- Stray m_done: pulse m_done while IDLE → no ack, state stays IDLE, grant = 00.

Source files
------------

// File: rtl/mod_sram_arbiter_if.sv
// Bus bundle between the I/D/V requesters, the arbiter and the SRAM controller.
// The arbiter takes the slave view; the requester/controller side takes master.
interface mod_sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  logic              v_req;
  logic [ADDR_W-1:0] v_addr;
  logic [DATA_W-1:0] v_rdata;
  logic              v_ack;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_done;

  logic [1:0]        grant;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, v_req, v_addr,
           m_rdata, m_done,
    output i_rdata, i_ack, d_rdata, d_ack, v_rdata, v_ack,
           m_req, m_we, m_addr, m_wdata, grant
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, v_req, v_addr,
           m_rdata, m_done,
    input  i_rdata, i_ack, d_rdata, d_ack, v_rdata, v_ack,
           m_req, m_we, m_addr, m_wdata, grant
  );
endinterface

// File: rtl/mod_sram_arbiter.sv
// Three-way SRAM port arbiter: D > I > V fixed priority, with VGA aging
// so frame fetches are promoted after VGA_MAX_WAIT cycles of waiting.
module mod_sram_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int VGA_MAX_WAIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mod_sram_arbiter_if.slave    bus
);

  localparam int VW_W = $clog2(VGA_MAX_WAIT + 1);
  localparam logic [VW_W-1:0] VMAX = VW_W'(VGA_MAX_WAIT);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'b00, OWN_I = 2'b01,
                            OWN_D = 2'b10, OWN_V = 2'b11} owner_t;

  state_t            state;
  owner_t            owner;
  owner_t            win;
  logic [VW_W-1:0]   vwait;

  logic              m_req_q, m_we_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q, v_rdata_q;
  logic              i_ack_q, d_ack_q, v_ack_q;

  always_comb begin
    win = OWN_NONE;
    if (bus.v_req && (vwait >= VMAX)) win = OWN_V;
    else if (bus.d_req)               win = OWN_D;
    else if (bus.i_req)               win = OWN_I;
    else if (bus.v_req)               win = OWN_V;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= OWN_NONE;
      vwait     <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      v_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      v_ack_q   <= 1'b0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      v_ack_q <= 1'b0;

      // Counter is zero while V owns the port, so holding it there is a no-op.
      if (!bus.v_req)
        vwait <= '0;
      else if (state == IDLE && win == OWN_V)
        vwait <= '0;
      else if (owner != OWN_V && vwait != VMAX)
        vwait <= vwait + 1'b1;

      case (state)
        IDLE: begin
          if (win != OWN_NONE) begin
            owner   <= win;
            state   <= BUSY;
            m_req_q <= 1'b1;
            case (win)
              OWN_D: begin
                m_addr_q  <= bus.d_addr;
                m_wdata_q <= bus.d_wdata;
                m_we_q    <= bus.d_we;
              end
              OWN_I: begin
                m_addr_q  <= bus.i_addr;
                m_wdata_q <= '0;
                m_we_q    <= 1'b0;
              end
              OWN_V: begin
                m_addr_q  <= bus.v_addr;
                m_wdata_q <= '0;
                m_we_q    <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        BUSY: begin
          if (bus.m_done) begin
            m_req_q <= 1'b0;
            m_we_q  <= 1'b0;
            state   <= RESP;
            case (owner)
              OWN_I: begin
                i_rdata_q <= bus.m_rdata;
                i_ack_q   <= 1'b1;
              end
              OWN_D: begin
                if (!m_we_q) d_rdata_q <= bus.m_rdata;
                d_ack_q <= 1'b1;
              end
              OWN_V: begin
                v_rdata_q <= bus.m_rdata;
                v_ack_q   <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        RESP: begin
          state <= IDLE;
          owner <= OWN_NONE;
        end
        default: begin
          state <= IDLE;
          owner <= OWN_NONE;
        end
      endcase
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.v_rdata = v_rdata_q;
  assign bus.i_ack   = i_ack_q;
  assign bus.d_ack   = d_ack_q;
  assign bus.v_ack   = v_ack_q;
  assign bus.grant   = owner;

endmodule

// File: tb/tb_mod_sram_arbiter.sv
// Directed bench for mod_sram_arbiter: reset, single reads, priority,
// VGA aging, mid-transaction reset and stray m_done.
module tb_mod_sram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  mod_sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mod_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .VGA_MAX_WAIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Acks packed as {i_ack, d_ack, v_ack}.
  task automatic chk_acks(input string tag, input logic [2:0] exp);
    chk(tag, {61'd0, bus.i_ack, bus.d_ack, bus.v_ack}, {61'd0, exp});
  endtask

  task automatic done_now(input logic [DW-1:0] rdata);
    bus.m_done  = 1'b1;
    bus.m_rdata = rdata;
    tick();
    bus.m_done  = 1'b0;
    bus.m_rdata = '0;
  endtask

  initial begin
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0100; bus.d_wdata = '0;
    bus.v_req = 1'b0; bus.v_addr = '0;
    bus.m_rdata = '0; bus.m_done = 1'b0;

    // Reset with D already requesting
    #2 rst = 1'b0;
    #1;
    chk("rst_m_req", bus.m_req, 0);
    chk("rst_grant", bus.grant, 0);
    chk_acks("rst_acks", 3'b000);
    chk("rst_m_addr", bus.m_addr, 0);
    tick(); tick();
    chk("rst_hold_m_req", bus.m_req, 0);
    chk("rst_hold_grant", bus.grant, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    chk("rst_m_we", bus.m_we, 0);
    rst = 1'b1;
    tick();
    chk("rel_m_req", bus.m_req, 1);
    chk("rel_m_addr", bus.m_addr, 32'h0000_0100);
    chk("rel_grant", bus.grant, 2);
    done_now(32'hA5A5_5A5A);
    chk_acks("rel_ack", 3'b010);
    chk("rel_d_rdata", bus.d_rdata, 32'hA5A5_5A5A);
    chk("rel_resp_m_req", bus.m_req, 0);
    bus.d_req = 1'b0;
    tick();
    chk_acks("rel_ack_gone", 3'b000);
    chk("rel_grant_idle", bus.grant, 0);

    // Single I read, four-cycle controller
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_1000;
    tick();
    chk("i_grant", bus.grant, 1);
    chk("i_m_req", bus.m_req, 1);
    chk("i_m_we", bus.m_we, 0);
    chk("i_m_addr", bus.m_addr, 32'h0000_1000);
    repeat (3) tick();
    chk("i_wait_m_req", bus.m_req, 1);
    chk_acks("i_wait_acks", 3'b000);
    chk("i_wait_m_we", bus.m_we, 0);
    done_now(32'hDEAD_BEEF);
    chk_acks("i_ack", 3'b100);
    chk("i_rdata", bus.i_rdata, 32'hDEAD_BEEF);
    chk("i_d_rdata_hold", bus.d_rdata, 32'hA5A5_5A5A);
    bus.i_req = 1'b0;
    tick();
    chk_acks("i_ack_gone", 3'b000);
    chk("i_grant_idle", bus.grant, 0);

    // D write beats I
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_2004; bus.d_wdata = 32'h1234_5678;
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_3000;
    tick();
    chk("dw_grant", bus.grant, 2);
    chk("dw_m_we", bus.m_we, 1);
    chk("dw_m_wdata", bus.m_wdata, 32'h1234_5678);
    chk("dw_m_addr", bus.m_addr, 32'h0000_2004);
    done_now(32'hFFFF_0000);
    chk_acks("dw_ack", 3'b010);
    chk("dw_d_rdata_hold", bus.d_rdata, 32'hA5A5_5A5A);
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    tick();
    chk("dw_gap_grant", bus.grant, 0);
    chk("dw_gap_m_req", bus.m_req, 0);
    tick();
    chk("dw_i_grant", bus.grant, 1);
    chk("dw_i_m_addr", bus.m_addr, 32'h0000_3000);
    chk("dw_i_m_we", bus.m_we, 0);
    done_now(32'h0BAD_F00D);
    chk_acks("dw_i_ack", 3'b100);
    chk("dw_i_rdata", bus.i_rdata, 32'h0BAD_F00D);
    bus.i_req = 1'b0;
    tick();

    // VGA aging while D and I keep the port busy
    bus.v_req = 1'b1; bus.v_addr = 32'h0000_8000;
    bus.d_req = 1'b1; bus.d_addr = 32'h0000_4000;
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_5000;
    tick();
    chk("age_d1_grant", bus.grant, 2);
    done_now(32'h0000_0001);
    chk_acks("age_d1_ack", 3'b010);
    bus.d_req = 1'b0;
    tick();
    tick();
    chk("age_i_grant", bus.grant, 1);
    done_now(32'h0000_0002);
    chk_acks("age_i_ack", 3'b100);
    bus.i_req = 1'b0; bus.d_req = 1'b1;
    tick();
    tick();
    chk("age_not_yet_grant", bus.grant, 2);
    done_now(32'h0000_0003);
    chk_acks("age_d2_ack", 3'b010);
    bus.d_req = 1'b0; bus.i_req = 1'b1;
    tick();
    bus.d_req = 1'b1;
    tick();
    chk("age_v_grant", bus.grant, 3);
    chk("age_v_m_addr", bus.m_addr, 32'h0000_8000);
    chk("age_v_m_we", bus.m_we, 0);
    done_now(32'h7654_3210);
    chk_acks("age_v_ack", 3'b001);
    chk("age_v_rdata", bus.v_rdata, 32'h7654_3210);
    bus.v_req = 1'b0;
    tick();
    tick();
    chk("age_after_d_grant", bus.grant, 2);
    done_now(32'h0000_0004);
    bus.d_req = 1'b0;
    tick();
    tick();
    chk("age_after_i_grant", bus.grant, 1);
    done_now(32'h0000_0005);
    bus.i_req = 1'b0;
    tick();

    // Reset while BUSY
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_6000;
    tick();
    chk("mid_busy_m_req", bus.m_req, 1);
    tick();
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_m_req", bus.m_req, 0);
    chk("mid_rst_grant", bus.grant, 0);
    chk_acks("mid_rst_acks", 3'b000);
    tick();
    rst = 1'b1;
    chk_acks("mid_rel_acks", 3'b000);
    tick();
    chk("mid_re_grant", bus.grant, 2);
    chk("mid_re_m_req", bus.m_req, 1);
    chk("mid_re_m_addr", bus.m_addr, 32'h0000_6000);
    chk_acks("mid_re_noack", 3'b000);
    done_now(32'h1111_2222);
    chk_acks("mid_re_ack", 3'b010);
    chk("mid_re_d_rdata", bus.d_rdata, 32'h1111_2222);
    bus.d_req = 1'b0;
    tick();

    // Stray m_done in IDLE
    bus.m_done = 1'b1; bus.m_rdata = 32'h0000_0099;
    tick();
    chk("stray_grant", bus.grant, 0);
    chk("stray_m_req", bus.m_req, 0);
    chk_acks("stray_acks", 3'b000);
    tick();
    chk("stray2_grant", bus.grant, 0);
    chk_acks("stray2_acks", 3'b000);
    chk("stray_d_rdata", bus.d_rdata, 32'h1111_2222);
    chk("stray_i_rdata", bus.i_rdata, 0);
    bus.m_done = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
